// File: rtl/cpu_types_pkg.sv
// Purpose : CPU-wide scalar types shared by datapath and control blocks.
// Latency : n/a (types only).
// Backpressure: n/a. Exports regbits_t (register number) and word_t (data word).
package cpu_types_pkg;
   localparam int REG_W  = 5;
   localparam int WORD_W = 32;

   typedef logic [REG_W-1:0]  regbits_t;
   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Purpose : Pipeline control types: datapath mux selects, hazard FSM states, stage controls.
// Latency : n/a (types, constants and a helper function only).
// Backpressure: n/a. Used by pipeline_hazard_ctrl, hazard_ctrl_if and the datapath.
package pipeline_hazard_ctrl_pkg;
   // Datapath mux selects
   typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR}  pc_sel_t;
   typedef enum logic [1:0] {FWD_NONE, FWD_EX_MEM, FWD_MEM_WB}   fwd_sel_t;
   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_LUI}     wb_sel_t;

   // Hazard controller states
   typedef enum logic [1:0] {RUN, HALT_DRAIN, HALTED} hz_state_t;

   // Stage load enables and bubble inserts, in pipeline order
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic if_id_flush;
      logic id_ex_flush;
   } stage_ctl_t;

   localparam stage_ctl_t CTL_NORMAL    = 6'b1111_00;
   localparam stage_ctl_t CTL_FREEZE    = 6'b0000_00;
   localparam stage_ctl_t CTL_BR_FLUSH  = 6'b1111_11;
   localparam stage_ctl_t CTL_LOAD_USE  = 6'b0011_01;
   localparam stage_ctl_t CTL_IMEM_WAIT = 6'b0111_10;
   localparam stage_ctl_t CTL_DRAIN     = 6'b0111_10;
   localparam stage_ctl_t CTL_DRAIN_FRZ = 6'b0000_10;
   localparam stage_ctl_t CTL_RESET     = 6'b0000_11;

   // Two unfrozen cycles carry the halt from EX through MEM and WB.
   localparam logic [1:0] DRAIN_INIT = 2'd2;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose : Bundles the hazard controller's pipeline status inputs and stage controls.
// Latency : n/a (wires only).
// Backpressure: n/a. Modport hazard_ctrl for the controller, tb for the driver side.
interface hazard_ctrl_if;
   import cpu_types_pkg::*;

   logic        ihit, dhit;
   logic        dREN_EX_MEM, dWEN_EX_MEM;
   logic        dREN_ID_EX, WEN_ID_EX;
   regbits_t    Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
   logic        branch_taken_EX, halt_ID_EX;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic        if_id_flush, id_ex_flush;
   logic        halt_out;
   logic [15:0] stall_cnt;

   modport hazard_ctrl (
      input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX, WEN_ID_EX,
             Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken_EX, halt_ID_EX,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
             halt_out, stall_cnt
   );

   modport tb (
      output ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX, WEN_ID_EX,
             Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken_EX, halt_ID_EX,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
             halt_out, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Purpose : Flags a load in EX whose destination is a source of the instruction in ID.
// Latency : combinational, 0 cycles.
// Backpressure: none. Ports: i_dren/i_wen_id_ex, i_rt_id_ex, i_rs/i_rt_if_id in; o_load_use out.
module load_use_detect
   import cpu_types_pkg::*;
(
   input  logic     i_dren_id_ex,
   input  logic     i_wen_id_ex,
   input  regbits_t i_rt_id_ex,
   input  regbits_t i_rs_if_id,
   input  regbits_t i_rt_if_id,
   output logic     o_load_use
);
   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign o_load_use = i_dren_id_ex & i_wen_id_ex & (i_rt_id_ex != '0) &
                       ((i_rt_id_ex == i_rs_if_id) | (i_rt_id_ex == i_rt_if_id));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : Stall/flush/halt control for a 5-stage pipeline, with a saturating stall counter.
// Latency : stage controls combinational from state+inputs; state and stall_cnt update on CLK.
// Backpressure: dmem wait freezes every stage. Ports: CLK, RST (sync, high), hif (hazard_ctrl).
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic                     CLK,
   input  logic                     RST,
   hazard_ctrl_if.hazard_ctrl       hif
);
   hz_state_t   r_state, w_state_nxt;
   logic [1:0]  r_drain_cnt, w_drain_nxt;
   logic [15:0] r_stall_cnt;
   stage_ctl_t  w_ctl;
   logic        w_halt_out;
   logic        w_load_use;
   logic        w_dmem_wait;

   load_use_detect u_load_use_detect (
      .i_dren_id_ex (hif.dREN_ID_EX),
      .i_wen_id_ex  (hif.WEN_ID_EX),
      .i_rt_id_ex   (hif.Rt_ID_EX),
      .i_rs_if_id   (hif.Rs_IF_ID),
      .i_rt_if_id   (hif.Rt_IF_ID),
      .o_load_use   (w_load_use)
   );

   assign w_dmem_wait = (hif.dREN_EX_MEM | hif.dWEN_EX_MEM) & ~hif.dhit;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= RUN;
         r_drain_cnt <= 2'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
         // A halted pipeline is not stalling, even though the PC is held.
         if (!w_ctl.pc_en && (r_state != HALTED))
            r_stall_cnt <= sat_inc16(r_stall_cnt);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain_cnt;
      w_ctl       = CTL_NORMAL;
      w_halt_out  = 1'b0;
      if (RST) begin
         w_state_nxt = RUN;
         w_drain_nxt = 2'd0;
         w_ctl       = CTL_RESET;
      end else begin
         case (r_state)
            RUN: begin
               if (w_dmem_wait) begin
                  w_ctl = CTL_FREEZE;
               end else begin
                  if (hif.branch_taken_EX)  w_ctl = CTL_BR_FLUSH;
                  else if (w_load_use)      w_ctl = CTL_LOAD_USE;
                  else if (!hif.ihit)       w_ctl = CTL_IMEM_WAIT;
                  // Halt wins over a same-cycle branch: the flushes still go out,
                  // but the redirect is irrelevant since fetch stops from here on.
                  if (hif.halt_ID_EX) begin
                     w_state_nxt = HALT_DRAIN;
                     w_drain_nxt = DRAIN_INIT;
                  end
               end
            end
            HALT_DRAIN: begin
               if (w_dmem_wait) begin
                  w_ctl = CTL_DRAIN_FRZ;
               end else begin
                  w_ctl = CTL_DRAIN;
                  if (r_drain_cnt <= 2'd1) begin
                     w_state_nxt = HALTED;
                     w_drain_nxt = 2'd0;
                  end else begin
                     w_drain_nxt = r_drain_cnt - 2'd1;
                  end
               end
            end
            HALTED: begin
               w_ctl      = CTL_FREEZE;
               w_halt_out = 1'b1;
            end
            default: begin
               w_state_nxt = RUN;
               w_drain_nxt = 2'd0;
            end
         endcase
      end
   end

   assign hif.pc_en       = w_ctl.pc_en;
   assign hif.if_id_en    = w_ctl.if_id_en;
   assign hif.id_ex_en    = w_ctl.id_ex_en;
   assign hif.ex_mem_en   = w_ctl.ex_mem_en;
   assign hif.if_id_flush = w_ctl.if_id_flush;
   assign hif.id_ex_flush = w_ctl.id_ex_flush;
   assign hif.halt_out    = w_halt_out;
   assign hif.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose : Directed self-checking bench for pipeline_hazard_ctrl.
// Latency : inputs change just after the falling edge; outputs sampled 1 time unit later.
// Backpressure: n/a. Control vector order: {pc_en,if_id_en,id_ex_en,ex_mem_en,if_id_flush,id_ex_flush}.
module tb_pipeline_hazard_ctrl;
   logic CLK;
   logic RST;
   int   n_total;
   int   n_pass;

   hazard_ctrl_if hif ();

   pipeline_hazard_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .hif (hif)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [5:0] ctl_v;
   assign ctl_v = {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en,
                   hif.if_id_flush, hif.id_ex_flush};

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      hif.ihit = 1'b1;            hif.dhit = 1'b1;
      hif.dREN_EX_MEM = 1'b0;     hif.dWEN_EX_MEM = 1'b0;
      hif.dREN_ID_EX = 1'b0;      hif.WEN_ID_EX = 1'b0;
      hif.Rt_ID_EX = 5'd0;        hif.Rs_IF_ID = 5'd0;  hif.Rt_IF_ID = 5'd0;
      hif.branch_taken_EX = 1'b0; hif.halt_ID_EX = 1'b0;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      RST = 1'b1;
      idle_inputs();

      // Reset state and outputs while RST is held
      tick(); #1;
      chk("rst_ctl", 16'(ctl_v), 16'h03);
      chk("rst_halt", 16'(hif.halt_out), 16'h0);
      chk("rst_cnt", hif.stall_cnt, 16'h0);
      tick();
      RST = 1'b0; #1;
      chk("run_normal", 16'(ctl_v), 16'h3C);

      // Load-use on Rs: one bubble, counter 0->1
      tick();
      hif.dREN_ID_EX = 1'b1; hif.WEN_ID_EX = 1'b1; hif.Rt_ID_EX = 5'd5; hif.Rs_IF_ID = 5'd5; #1;
      chk("lu_rs_ctl", 16'(ctl_v), 16'h0D);
      tick();
      hif.dREN_ID_EX = 1'b0; #1;
      chk("lu_bubble_ctl", 16'(ctl_v), 16'h3C);
      chk("lu_cnt", hif.stall_cnt, 16'd1);

      // Load-use on Rt
      tick();
      hif.dREN_ID_EX = 1'b1; hif.Rt_ID_EX = 5'd7; hif.Rs_IF_ID = 5'd3; hif.Rt_IF_ID = 5'd7; #1;
      chk("lu_rt_ctl", 16'(ctl_v), 16'h0D);
      // Same load targeting r0: no stall
      tick();
      hif.Rt_ID_EX = 5'd0; hif.Rs_IF_ID = 5'd0; hif.Rt_IF_ID = 5'd0; #1;
      chk("lu_r0_ctl", 16'(ctl_v), 16'h3C);
      // Matching register but no register write: no stall
      tick();
      hif.Rt_ID_EX = 5'd9; hif.Rs_IF_ID = 5'd9; hif.WEN_ID_EX = 1'b0; #1;
      chk("lu_nowen_ctl", 16'(ctl_v), 16'h3C);
      chk("lu_cnt2", hif.stall_cnt, 16'd2);
      tick();
      idle_inputs();

      // Dmem wait over branch for 3 cycles, then both flushes
      hif.dREN_EX_MEM = 1'b1; hif.dhit = 1'b0; hif.branch_taken_EX = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("dwait_ctl", 16'(ctl_v), 16'h00);
         tick();
      end
      hif.dhit = 1'b1; #1;
      chk("dwait_done_ctl", 16'(ctl_v), 16'h3F);
      chk("dwait_cnt", hif.stall_cnt, 16'd5);
      tick();
      // Store wait beats a load-use
      idle_inputs();
      hif.dWEN_EX_MEM = 1'b1; hif.dhit = 1'b0;
      hif.dREN_ID_EX = 1'b1; hif.WEN_ID_EX = 1'b1; hif.Rt_ID_EX = 5'd4; hif.Rs_IF_ID = 5'd4; #1;
      chk("swait_lu_ctl", 16'(ctl_v), 16'h00);
      tick();
      // Branch beats load-use
      hif.dWEN_EX_MEM = 1'b0; hif.dhit = 1'b1; hif.branch_taken_EX = 1'b1; #1;
      chk("br_lu_ctl", 16'(ctl_v), 16'h3F);
      chk("br_cnt", hif.stall_cnt, 16'd6);
      tick();
      idle_inputs();

      // Imem wait for 2 cycles, then resume
      hif.ihit = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("iwait_ctl", 16'(ctl_v), 16'h1E);
         tick();
      end
      hif.ihit = 1'b1; #1;
      chk("iwait_done_ctl", 16'(ctl_v), 16'h3C);
      chk("iwait_cnt", hif.stall_cnt, 16'd8);
      tick();
      // Load-use beats imem wait
      hif.ihit = 1'b0; hif.dREN_ID_EX = 1'b1; hif.WEN_ID_EX = 1'b1;
      hif.Rt_ID_EX = 5'd2; hif.Rt_IF_ID = 5'd2; #1;
      chk("lu_iwait_ctl", 16'(ctl_v), 16'h0D);
      tick();
      idle_inputs();

      // Halt: 2 drain cycles, then halted indefinitely
      hif.halt_ID_EX = 1'b1; #1;
      chk("halt_issue_ctl", 16'(ctl_v), 16'h3C);
      tick();
      hif.halt_ID_EX = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("drain_ctl", 16'(ctl_v), 16'h1E);
         chk("drain_halt", 16'(hif.halt_out), 16'h0);
         tick();
      end
      hif.ihit = 1'b0; #1;
      chk("halted_ctl", 16'(ctl_v), 16'h00);
      chk("halted_halt", 16'(hif.halt_out), 16'h1);
      chk("halted_cnt", hif.stall_cnt, 16'd11);
      for (int i = 0; i < 4; i++) tick();
      hif.halt_ID_EX = 1'b1; #1;
      chk("halted_hold", 16'(hif.halt_out), 16'h1);
      chk("halted_cnt_hold", hif.stall_cnt, 16'd11);

      // Reset out of HALTED
      RST = 1'b1; #1;
      chk("rst2_ctl", 16'(ctl_v), 16'h03);
      chk("rst2_halt", 16'(hif.halt_out), 16'h0);
      tick();
      RST = 1'b0;
      idle_inputs(); #1;
      chk("rst2_run_ctl", 16'(ctl_v), 16'h3C);
      chk("rst2_cnt", hif.stall_cnt, 16'd0);

      // Halt with same-cycle branch, then a 2-cycle dmem wait mid-drain
      hif.halt_ID_EX = 1'b1; hif.branch_taken_EX = 1'b1; #1;
      chk("halt_br_ctl", 16'(ctl_v), 16'h3F);
      tick();
      idle_inputs(); #1;
      chk("drain1_ctl", 16'(ctl_v), 16'h1E);
      tick();
      hif.dREN_EX_MEM = 1'b1; hif.dhit = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("drain_frz_ctl", 16'(ctl_v), 16'h02);
         chk("drain_frz_halt", 16'(hif.halt_out), 16'h0);
         tick();
      end
      hif.dhit = 1'b1; #1;
      chk("drain2_ctl", 16'(ctl_v), 16'h1E);
      chk("drain2_halt", 16'(hif.halt_out), 16'h0);
      tick();
      #1;
      chk("halted2_halt", 16'(hif.halt_out), 16'h1);
      chk("halted2_cnt", hif.stall_cnt, 16'd4);

      // Reset mid-pipeline, then saturate the stall counter
      RST = 1'b1;
      tick();
      RST = 1'b0;
      idle_inputs();
      hif.ihit = 1'b0;
      for (int i = 0; i < 65540; i++) tick();
      #1;
      chk("sat_cnt", hif.stall_cnt, 16'hFFFF);
      for (int i = 0; i < 5; i++) tick();
      #1;
      chk("sat_hold", hif.stall_cnt, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
